// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel bundle between a crossbar output port and a responder.
interface tl_ram_responder_if #(parameter int ADDR_W = 7);
  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [1:0]        a_size;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              d_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_size;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_corrupt;

  modport master (
    input  a_ready, d_valid, d_opcode, d_size, d_denied, d_data, d_corrupt,
    output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready
  );
  modport slave (
    output a_ready, d_valid, d_opcode, d_size, d_denied, d_data, d_corrupt,
    input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready
  );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UL scratchpad responder: one request stage (S1) feeding an in-order
// response FIFO; a_ready is a credit check on S1 + FIFO occupancy.
module tl_ram_responder #(
  parameter int ADDR_W  = 7,
  parameter int DEPTH   = 24,
  parameter int Q_DEPTH = 3
) (
  input logic             clock,
  input logic             reset,
  tl_ram_responder_if.slave tl
);
  localparam int IW = ADDR_W - 2;
  localparam int CW = $clog2(Q_DEPTH + 1);
  localparam int PW = $clog2(Q_DEPTH);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } resp_t;

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic          hit, is_get, is_put, fire;
  resp_t         a_rsp, s1, head;
  logic          s1_valid;
  resp_t         q [Q_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_count;
  logic          push, pop;

  assign idx    = tl.a_address[ADDR_W-1:2];
  // widened compare so DEPTH == 2^IW does not truncate to zero
  assign hit    = {1'b0, idx} < (IW+1)'(DEPTH);
  assign is_get = tl.a_opcode == 3'd4;
  assign is_put = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
  assign fire   = tl.a_valid & tl.a_ready;

  always_comb begin
    a_rsp      = '0;
    a_rsp.size = tl.a_size;
    if (is_get) begin
      a_rsp.opcode  = 3'd1;
      a_rsp.denied  = !hit;
      a_rsp.corrupt = !hit;
      a_rsp.data    = hit ? mem[idx] : 32'd0;
    end else begin
      a_rsp.opcode  = 3'd0;
      a_rsp.denied  = !(hit && is_put);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && fire && is_put && hit)
      for (int b = 0; b < 4; b++)
        if (tl.a_mask[b]) mem[idx][8*b +: 8] <= tl.a_data[8*b +: 8];
  end

  always_ff @(posedge clock) begin
    if (!reset) s1_valid <= 1'b0;
    else begin
      s1_valid <= fire;
      if (fire) s1 <= a_rsp;
    end
  end

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = s1_valid;
  assign pop  = (q_count != '0) && tl.d_ready;

  always_ff @(posedge clock) begin
    if (reset && push) q[wr_ptr] <= s1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  assign head         = q[rd_ptr];
  assign tl.a_ready   = (q_count + CW'(s1_valid)) < CW'(Q_DEPTH);
  assign tl.d_valid   = q_count != '0;
  assign tl.d_opcode  = head.opcode;
  assign tl.d_size    = head.size;
  assign tl.d_denied  = head.denied;
  assign tl.d_corrupt = head.corrupt;
  assign tl.d_data    = head.data;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(push && !pop && q_count == CW'(Q_DEPTH))) else $error("response fifo overflow");
      assert (q_count <= CW'(Q_DEPTH)) else $error("response fifo count out of range");
    end
  end
`endif
endmodule
